// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, debounce FSM and
// single-cycle press/release pulses for the stopwatch start/stop/clear inputs.
module btn_conditioner #(
    parameter int unsigned N_BTN     = 3,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitHi,
        StHigh,
        StWaitLo
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             s;

        assign s = sync2_q[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Counter is cleared on every state change and saturates at CntMax.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s) begin
                        state_d = StWaitHi;
                        cnt_d   = '0;
                    end
                end
                StWaitHi: begin
                    if (!s) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StHigh: begin
                    if (!s) begin
                        state_d = StWaitLo;
                        cnt_d   = '0;
                    end
                end
                StWaitLo: begin
                    if (s) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random
// button activity compared against a run-length debounce model.
module tb_btn_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_in;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;

    int n_vec;
    int n_err;

    // Model: 2-sample delay line, then a level flips once the delayed input
    // has disagreed with it on DB+1 consecutive edges.
    logic [2:0] m_s1, m_s2, m_level, m_press, m_rel;
    int         m_run[3];

    btn_conditioner #(
        .N_BTN    (3),
        .DB_CYCLES(DB),
        .CNT_W    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [2:0] b, input logic r);
        logic [2:0] s;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < 3; c++) m_run[c] = 0;
        end else begin
            s       = m_s2;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < 3; c++) begin
                if (s[c] != m_level[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DB + 1) begin
                    m_run[c]   = 0;
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) m_press[c] = 1'b1;
                    else m_rel[c] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    // Drive inputs, take one edge, advance the model and compare.
    task automatic cycle(input logic [2:0] b, input logic r);
        btn_in = b;
        rst_n  = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check_eq("level", 32'(btn_level), 32'(m_level));
        check_eq("press", 32'(btn_press), 32'(m_press));
        check_eq("release", 32'(btn_release), 32'(m_rel));
        check_eq("excl", 32'(btn_press & btn_release), 0);
    endtask

    initial begin
        int         hit;
        int         pulses;
        logic [2:0] b;
        n_vec  = 0;
        n_err  = 0;
        btn_in = '0;
        rst_n  = 1'b0;
        for (int c = 0; c < 3; c++) m_run[c] = 0;
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;

        // 1. Reset, then quiet for 20 cycles.
        cycle(3'b000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(3'b000, 1'b1);
            check_eq("rst_quiet", 32'({btn_level, btn_press, btn_release}), 0);
        end

        // 2. Clean press on channel 0: pulse at E0+DB+2, then level holds.
        hit = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(3'b001, 1'b1);
            if (btn_press[0]) begin
                pulses++;
                if (hit < 0) hit = i;
            end
        end
        check_eq("press_lat", hit, DB + 2);
        check_eq("press_once", pulses, 1);
        check_eq("press_level", 32'(btn_level[0]), 1);

        // 3. Bounce on channel 1 (high runs of 3), then stable high.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle({1'b0, (i % 4) != 3, 1'b1}, 1'b1);
            if (btn_press[1] || btn_level[1]) pulses++;
        end
        check_eq("bounce_quiet", pulses, 0);
        hit = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(3'b011, 1'b1);
            if (btn_press[1]) begin
                pulses++;
                if (hit < 0) hit = i;
            end
        end
        check_eq("bounce_lat", hit, DB + 2);
        check_eq("bounce_once", pulses, 1);

        // 4. Channel 2: press, 2-cycle low glitch ignored, then real release.
        for (int i = 0; i < 10; i++) cycle(3'b111, 1'b1);
        check_eq("ch2_high", 32'(btn_level[2]), 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle((i < 2) ? 3'b011 : 3'b111, 1'b1);
            if (btn_release[2]) pulses++;
        end
        check_eq("glitch_norel", pulses, 0);
        hit = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(3'b011, 1'b1);
            if (btn_release[2] && hit < 0) hit = i;
        end
        check_eq("rel_lat", hit, DB + 2);
        check_eq("rel_level", 32'(btn_level[2]), 0);

        // 5. Simultaneous press on all channels.
        for (int i = 0; i < 12; i++) cycle(3'b000, 1'b1);
        check_eq("all_low", 32'(btn_level), 0);
        hit = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(3'b111, 1'b1);
            if (btn_press != 3'b000 && hit < 0) begin
                hit = i;
                check_eq("simul_press", 32'(btn_press), 32'h7);
            end
            if (hit >= 0 && i == hit + 1) check_eq("simul_one", 32'(btn_press), 0);
        end
        check_eq("simul_lat", hit, DB + 2);

        // 6. Reset while channel 0 sits in WAIT_HI with cnt=2.
        for (int i = 0; i < 12; i++) cycle(3'b000, 1'b1);
        for (int i = 0; i < 5; i++) cycle(3'b001, 1'b1);
        cycle(3'b001, 1'b0);
        check_eq("midrst_out", 32'({btn_level, btn_press, btn_release}), 0);
        hit = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(3'b001, 1'b1);
            if (btn_press[0]) begin
                pulses++;
                if (hit < 0) hit = i;
            end
        end
        check_eq("midrst_lat", hit, DB + 2);
        check_eq("midrst_once", pulses, 1);

        // Random activity with long and short runs and rare resets.
        b = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 6) == 0) b[c] = ~b[c];
            cycle(b, ($urandom_range(0, 299) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
